score_display_scan: RTL and testbench

Sequential display driver that time-multiplexes both players' Pong scores onto the shared 4-digit, common-anode seven-segment display. It is the demultiplexing end of the display path: one cathode bus and one segment-decode path are shared, and a refresh counter steps the active anode across the digits. The block sits between the score counters and the board pins, and captures a snapshot of the scores once per scan frame so that a score change never tears mid-frame.

---
 rtl/score_display_scan_pkg.sv | 42 ++++
 rtl/score_display_scan_if.sv | 29 ++
 rtl/score_display_scan_bcd_to_7seg.sv | 26 ++
 rtl/score_display_scan.sv | 103 ++++++++++
 tb/tb_score_display_scan.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/score_display_scan_pkg.sv
// Shared Pong display constants: active-low {g,f,e,d,c,b,a} segment patterns,
// score limit and the digit index type used by the scan driver.
package pong_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    localparam logic [6:0] MAX_SCORE = 7'd99;

    typedef enum logic [1:0] {
        DIG_R_ONES = 2'd0,
        DIG_R_TENS = 2'd1,
        DIG_L_ONES = 2'd2,
        DIG_L_TENS = 2'd3
    } digit_idx_t;

    function automatic logic [6:0] saturate_score(input logic [6:0] score);
        return (score > MAX_SCORE) ? MAX_SCORE : score;
    endfunction

    // Active-low anode strobe for each digit slot; idx0 is the rightmost digit.
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] an;
        case (idx)
            DIG_R_ONES: an = 4'b1110;
            DIG_R_TENS: an = 4'b1101;
            DIG_L_ONES: an = 4'b1011;
            default:    an = 4'b0111;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/score_display_scan_if.sv
// Score inputs and display pin outputs of the scan driver; the driver takes the slave side.
interface score_display_scan_if;

    logic [6:0] left_score;
    logic [6:0] right_score;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    modport master (
        output left_score,
        output right_score,
        input  an,
        input  seg,
        input  dp,
        input  frame_start
    );

    modport slave (
        input  left_score,
        input  right_score,
        output an,
        output seg,
        output dp,
        output frame_start
    );

endinterface

// File: rtl/score_display_scan_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 decode as blank.
module bcd_to_7seg
    import pong_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed 4-digit score display driver with a once-per-frame score snapshot.
// Optional feature macro: BLANK_LEADING_ZERO_EN (blanks a zero tens digit).
module score_display_scan
    import pong_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    score_display_scan_if.slave  bus
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [6:0]       left_snap_q, left_snap_d;
    logic [6:0]       right_snap_q, right_snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tc;
    logic             frame_tc;
    logic [3:0]       left_tens, left_ones, right_tens, right_ones;
    logic [3:0]       digit;
    logic [6:0]       dec_seg;

    assign tc       = (div_cnt_q == CNT_LAST);
    assign frame_tc = tc && (idx_q == DIG_L_TENS);

    // The snapshot is taken on the idx3->idx0 boundary so a frame never mixes old and new scores.
    always_comb begin
        div_cnt_d    = tc ? '0 : div_cnt_q + 1'b1;
        idx_d        = tc ? digit_idx_t'(idx_q + 2'd1) : idx_q;
        left_snap_d  = frame_tc ? saturate_score(bus.left_score)  : left_snap_q;
        right_snap_d = frame_tc ? saturate_score(bus.right_score) : right_snap_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            idx_q        <= DIG_R_ONES;
            left_snap_q  <= '0;
            right_snap_q <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            left_snap_q  <= left_snap_d;
            right_snap_q <= right_snap_d;
        end
    end

    assign left_tens  = 4'(left_snap_q  / 7'd10);
    assign left_ones  = 4'(left_snap_q  % 7'd10);
    assign right_tens = 4'(right_snap_q / 7'd10);
    assign right_ones = 4'(right_snap_q % 7'd10);

    always_comb begin
        digit = right_ones;
        case (idx_q)
            DIG_R_ONES: digit = right_ones;
            DIG_R_TENS: digit = right_tens;
            DIG_L_ONES: digit = left_ones;
            default:    digit = left_tens;
        endcase
    end

    bcd_to_7seg u_bcd_to_7seg (
        .bcd_i (digit),
        .seg_o (dec_seg)
    );

    // Tens slots are the odd indices; a blanked tens digit still strobes its anode.
    always_comb begin
        an_d = anode_for(idx_q);
        dp_d = (idx_q != DIG_L_ONES);
`ifdef BLANK_LEADING_ZERO_EN
        seg_d = (idx_q[0] && (digit == 4'd0)) ? SEG_BLANK : dec_seg;
`else
        seg_d = dec_seg;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_tc;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed, table-driven bench for score_display_scan at REFRESH_DIV=4.
// Honours BLANK_LEADING_ZERO_EN when expecting tens digits.
module tb_score_display_scan;

    localparam int REFRESH_DIV = 4;

    typedef struct packed {
        logic [6:0]      left;
        logic [6:0]      right;
        logic [3:0][6:0] expSeg;
    } vector_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    score_display_scan_if bus ();

    score_display_scan #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] left, input logic [6:0] right);
        bus.left_score  = left;
        bus.right_score = right;
    endtask

    function automatic logic [6:0] segModel(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] tensAdjust(input logic [6:0] p);
`ifdef BLANK_LEADING_ZERO_EN
        return (p == 7'h40) ? 7'h7F : p;
`else
        return p;
`endif
    endfunction

    function automatic logic [3:0][6:0] adjustFrame(input logic [3:0][6:0] f);
        logic [3:0][6:0] r;
        r    = f;
        r[1] = tensAdjust(f[1]);
        r[3] = tensAdjust(f[3]);
        return r;
    endfunction

    function automatic logic [3:0][6:0] frameModel(input int left, input int right);
        logic [3:0][6:0] r;
        int ls, rs;
        ls = (left  > 99) ? 99 : left;
        rs = (right > 99) ? 99 : right;
        r[0] = segModel(rs % 10);
        r[1] = segModel(rs / 10);
        r[2] = segModel(ls % 10);
        r[3] = segModel(ls / 10);
        return adjustFrame(r);
    endfunction

    function automatic logic [3:0] anodeFor(input int slot);
        case (slot)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [6:0] zeroSlot(input int slot);
        return (slot % 2 == 1) ? tensAdjust(7'h40) : 7'h40;
    endfunction

    task automatic waitFrameStart(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 * REFRESH_DIV && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.frame_start === 1'b1) found = 1'b1;
        end
        checkOutput($sformatf("%s frame_start seen", tag), 32'(found), 32'd1);
    endtask

    // Called at the negedge where frame_start was seen; samples every slot of the next frame.
    task automatic checkFrame(input logic [3:0][6:0] expSeg, input bit scramble, input string tag);
        for (int slot = 0; slot < 4; slot++) begin
            repeat ((slot == 0) ? 2 : REFRESH_DIV) begin
                @(posedge clk);
                @(negedge clk);
                if (scramble) applyStimulus(7'($urandom), 7'($urandom));
            end
            checkOutput($sformatf("%s slot%0d an", tag, slot), 32'(bus.an), 32'(anodeFor(slot)));
            checkOutput($sformatf("%s slot%0d seg", tag, slot), 32'(bus.seg), 32'(expSeg[slot]));
            checkOutput($sformatf("%s slot%0d dp", tag, slot), 32'(bus.dp), (slot == 2) ? 32'd0 : 32'd1);
        end
    endtask

    vector_t vectors[7];

    initial begin
        int c;
        int tl, tr;
        bit found;

        checks = 0;
        errors = 0;

        vectors[0] = '{left: 7'd42,  right: 7'd7,  expSeg: {7'h19, 7'h24, 7'h40, 7'h78}};
        vectors[1] = '{left: 7'd120, right: 7'd99, expSeg: {7'h10, 7'h10, 7'h10, 7'h10}};
        vectors[2] = '{left: 7'd55,  right: 7'd13, expSeg: {7'h12, 7'h12, 7'h79, 7'h30}};
        vectors[3] = '{left: 7'd100, right: 7'd68, expSeg: {7'h10, 7'h10, 7'h02, 7'h00}};
        vectors[4] = '{left: 7'd9,   right: 7'd90, expSeg: {7'h40, 7'h10, 7'h10, 7'h40}};
        vectors[5] = '{left: 7'd0,   right: 7'd0,  expSeg: {7'h40, 7'h40, 7'h40, 7'h40}};
        vectors[6] = '{left: 7'd127, right: 7'd10, expSeg: {7'h10, 7'h10, 7'h79, 7'h40}};

        // Reset values and the first scanned frame with a zero snapshot
        reset = 1'b1;
        applyStimulus(7'd0, 7'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset an", 32'(bus.an), 32'hF);
        checkOutput("reset seg", 32'(bus.seg), 32'h7F);
        checkOutput("reset dp", 32'(bus.dp), 32'd1);
        checkOutput("reset frame_start", 32'(bus.frame_start), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("release cycle1 an", 32'(bus.an), 32'hF);
        checkOutput("release cycle1 seg", 32'(bus.seg), 32'h7F);
        for (c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("scan c%0d an", c), 32'(bus.an), 32'(anodeFor((c / 4) % 4)));
            checkOutput($sformatf("scan c%0d seg", c), 32'(bus.seg), 32'(zeroSlot((c / 4) % 4)));
            checkOutput($sformatf("scan c%0d dp", c), 32'(bus.dp), ((c / 4) % 4 == 2) ? 32'd0 : 32'd1);
            checkOutput($sformatf("scan c%0d frame_start", c), 32'(bus.frame_start), (c == 14) ? 32'd1 : 32'd0);
        end

        // Mid-frame score change stays invisible until the idx3->idx0 boundary
        applyStimulus(7'd42, 7'd7);
        for (c = 16; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("hold c%0d seg", c), 32'(bus.seg), 32'(zeroSlot((c / 4) % 4)));
            checkOutput($sformatf("hold c%0d frame_start", c), 32'(bus.frame_start), (c == 30) ? 32'd1 : 32'd0);
        end
        checkFrame(adjustFrame(vectors[0].expSeg), 1'b0, "midframe");

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vectors[v].left, vectors[v].right);
            waitFrameStart($sformatf("vec%0d", v));
            checkFrame(adjustFrame(vectors[v].expSeg), 1'b1, $sformatf("vec%0d", v));
        end

        // Inputs toggle every cycle; only the value present at the frame TC may be shown
        tl = 0;
        tr = 0;
        found = 1'b0;
        for (int i = 0; i < 8 * REFRESH_DIV && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            tl = (i * 13 + 5) % 128;
            tr = (i * 29 + 3) % 128;
            applyStimulus(7'(tl), 7'(tr));
            if (bus.frame_start === 1'b1) found = 1'b1;
        end
        checkOutput("toggle frame_start seen", 32'(found), 32'd1);
        checkFrame(frameModel(tl, tr), 1'b1, "toggle");

        // Reset during idx2 clears outputs immediately and drops the snapshot
        applyStimulus(7'd42, 7'd7);
        waitFrameStart("prereset");
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("prereset an idx2", 32'(bus.an), 32'hB);
        reset = 1'b1;
        #1;
        checkOutput("midreset an", 32'(bus.an), 32'hF);
        checkOutput("midreset seg", 32'(bus.seg), 32'h7F);
        checkOutput("midreset dp", 32'(bus.dp), 32'd1);
        checkOutput("midreset frame_start", 32'(bus.frame_start), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rerelease cycle1 an", 32'(bus.an), 32'hF);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rerelease an", 32'(bus.an), 32'hE);
        checkOutput("rerelease seg", 32'(bus.seg), 32'h40);
        checkOutput("rerelease dp", 32'(bus.dp), 32'd1);
        waitFrameStart("postreset");
        checkFrame(adjustFrame(vectors[0].expSeg), 1'b0, "postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
